// File: rtl/ps_resp_pkg.sv
// Shared response codes, output FSM encoding and header length decode
// for the permutation-switch return-path merger.
package ps_resp_pkg;

    localparam logic [2:0] RD_RSP = 3'b011;
    localparam logic [2:0] WR_RSP = 3'b100;
    localparam int         NPORTS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } out_state_e;

    typedef struct packed {
        logic       illegal;
        logic [9:0] len;
    } body_len_t;

    // Body byte count that follows a header; bits [7:6] carry no meaning.
    function automatic body_len_t body_len(input logic [7:0] hdr);
        body_len_t r;
        r.illegal = 1'b0;
        r.len     = 10'd0;
        case (hdr[2:0])
            RD_RSP:  r.len = 10'd2 + (10'd1 << hdr[5:3]);
            WR_RSP:  r.len = 10'd2;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Byte FIFO whose writes stay invisible to the reader until the framer
// commits them; an aborted frame is dropped by rewinding to the commit point.
module resp_fifo #(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    input  logic                   commit_i,
    input  logic                   rewind_i,
    input  logic                   pop_i,
    input  logic                   frame_pop_i,
    output logic [7:0]             pop_data_o,
    output logic [$clog2(DEPTH):0] free_o,
    output logic                   has_frame_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_spec_q, wr_spec_d;
    logic [PW-1:0] wr_cmt_q, wr_cmt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] frames_q, frames_d;
    logic [PW-1:0] wr_base;

    // A rewind and a new header can land together: the header goes at the commit point.
    always_comb begin
        wr_base   = rewind_i ? wr_cmt_q : wr_spec_q;
        wr_spec_d = wr_base + PW'(push_i);
        wr_cmt_d  = commit_i ? wr_spec_d : wr_cmt_q;
        rd_d      = rd_q + PW'(pop_i);
        frames_d  = frames_q + PW'(commit_i) - PW'(frame_pop_i);
    end

    assign free_o      = PW'(DEPTH) - (wr_base - rd_q);
    assign has_frame_o = (frames_q != '0);
    assign pop_data_o  = mem[rd_q[AW-1:0]];

    // NOTE: non-blocking assignments, so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_spec_q <= '0;
            wr_cmt_q  <= '0;
            rd_q      <= '0;
            frames_q  <= '0;
        end else begin
            wr_spec_q <= wr_spec_d;
            wr_cmt_q  <= wr_cmt_d;
            rd_q      <= rd_d;
            frames_q  <= frames_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_base[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ps_resp_merge.sv
// Store-and-forward merger of four perm-device response links onto one
// NOC return link, round-robin between ports with one idle cycle per frame.
module ps_resp_merge
    import ps_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      dev_ctl,
    input  logic [3:0][7:0] dev_data,
    output logic            noc_from_dev_ctl,
    output logic [7:0]      noc_from_dev_data,
    output logic [3:0]      ovf,
    output logic [3:0]      err
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [3:0]    push, commit, rewind, pop, frame_pop, has_frame;
    logic [3:0]    ovf_set, err_set;
    logic [7:0]    pop_data [NPORTS];
    logic [FW-1:0] free [NPORTS];
    body_len_t     in_hd [NPORTS];

    logic [9:0]    rem_q [NPORTS];
    logic [9:0]    rem_d [NPORTS];
    logic [3:0]    drop_q, drop_d;
    logic [3:0]    ovf_q, err_q;

    out_state_e    state_q, state_d;
    logic [1:0]    rr_q, rr_d, gnt_q, gnt_d, sel, cand;
    logic          found;
    logic [9:0]    cnt_q, cnt_d;
    logic          ctl_q, ctl_d;
    logic [7:0]    data_q, data_d;
    body_len_t     out_hd;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        resp_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push_i      (push[p]),
            .push_data_i (dev_data[p]),
            .commit_i    (commit[p]),
            .rewind_i    (rewind[p]),
            .pop_i       (pop[p]),
            .frame_pop_i (frame_pop[p]),
            .pop_data_o  (pop_data[p]),
            .free_o      (free[p]),
            .has_frame_o (has_frame[p])
        );
    end

    // Per-port input framers.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        push    = '0;
        commit  = '0;
        rewind  = '0;
        ovf_set = '0;
        err_set = '0;
        drop_d  = drop_q;
        rem_d   = rem_q;
        for (int p = 0; p < NPORTS; p++) begin
            in_hd[p] = body_len(dev_data[p]);
            if (dev_ctl[p]) begin
                if (rem_q[p] != 10'd0) begin
                    rewind[p]  = 1'b1;
                    err_set[p] = 1'b1;
                    rem_d[p]   = 10'd0;
                end
                if (dev_data[p] != 8'd0) begin
                    drop_d[p] = 1'b1;
                    if (in_hd[p].illegal) begin
                        err_set[p] = 1'b1;
                    end else if (32'(free[p]) >= 32'(in_hd[p].len) + 32'd1) begin
                        push[p]   = 1'b1;
                        rem_d[p]  = in_hd[p].len;
                        drop_d[p] = 1'b0;
                    end else begin
                        ovf_set[p] = 1'b1;
                    end
                end
            end else if (rem_q[p] != 10'd0) begin
                push[p]   = 1'b1;
                rem_d[p]  = rem_q[p] - 10'd1;
                commit[p] = (rem_q[p] == 10'd1);
            end else if (!drop_q[p]) begin
                err_set[p] = 1'b1;
            end
        end
    end

    // Output arbiter and sender.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        ctl_d     = 1'b1;
        data_d    = 8'd0;
        pop       = '0;
        frame_pop = '0;
        found     = 1'b0;
        sel       = rr_q;
        cand      = rr_q;
        for (int i = 0; i < NPORTS; i++) begin
            cand = rr_q + 2'(i);
            if (!found && has_frame[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        out_hd = body_len(pop_data[sel]);

        case (state_q)
            IDLE: begin
                if (found) begin
                    pop[sel]       = 1'b1;
                    frame_pop[sel] = 1'b1;
                    data_d         = pop_data[sel];
                    cnt_d          = out_hd.len;
                    gnt_d          = sel;
                    rr_d           = sel + 2'd1;
                    // Only legal headers are ever buffered; this guard just keeps SEND sane.
                    state_d        = out_hd.illegal ? GAP : SEND;
                end
            end
            SEND: begin
                pop[gnt_q] = 1'b1;
                ctl_d      = 1'b0;
                data_d     = pop_data[gnt_q];
                cnt_d      = cnt_q - 10'd1;
                if (cnt_q == 10'd1) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ctl_q   <= 1'b1;
            data_q  <= '0;
            ovf_q   <= '0;
            err_q   <= '0;
            rem_q   <= '{default: '0};
            // Leftover body bytes of a frame cut by reset are ignored rather than flagged.
            drop_q  <= '1;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            data_q  <= data_d;
            ovf_q   <= ovf_q | ovf_set;
            err_q   <= err_q | err_set;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
        end
    end

    assign noc_from_dev_ctl  = ctl_q;
    assign noc_from_dev_data = data_q;
    assign ovf               = ovf_q;
    assign err               = err_q;

endmodule

// File: tb/tb_ps_resp_merge.sv
// Directed bench for ps_resp_merge: cycle-exact vector tables plus
// hand-written sequences for overflow and mid-frame reset.
module tb_ps_resp_merge;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] data;      // {port3, port2, port1, port0}
        logic        exp_ctl;
        logic [7:0]  exp_data;  // output expected just after this vector's edge
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      dev_ctl = 4'hF;
    logic [3:0][7:0] dev_data = '0;
    logic            out_ctl;
    logic [7:0]      out_data;
    logic [3:0]      ovf, err;

    logic [3:0]      dev_ctl16 = 4'hF;
    logic [3:0][7:0] dev_data16 = '0;
    logic            out_ctl16;
    logic [7:0]      out_data16;
    logic [3:0]      ovf16, err16;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    ps_resp_merge dut (
        .clk               (clk),
        .reset             (reset),
        .dev_ctl           (dev_ctl),
        .dev_data          (dev_data),
        .noc_from_dev_ctl  (out_ctl),
        .noc_from_dev_data (out_data),
        .ovf               (ovf),
        .err               (err)
    );

    ps_resp_merge #(.DEPTH(16)) dut16 (
        .clk               (clk),
        .reset             (reset),
        .dev_ctl           (dev_ctl16),
        .dev_data          (dev_data16),
        .noc_from_dev_ctl  (out_ctl16),
        .noc_from_dev_data (out_data16),
        .ovf               (ovf16),
        .err               (err16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [31:0] d,
                       input logic ec, input logic [7:0] ed);
        vec_t v;
        v.ctl      = c;
        v.data     = d;
        v.exp_ctl  = ec;
        v.exp_data = ed;
        vq.push_back(v);
    endtask

    task automatic run_vectors(input string name);
        foreach (vq[i]) begin
            dev_ctl  = vq[i].ctl;
            dev_data = vq[i].data;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", name, i),
                  {23'd0, out_ctl, out_data},
                  {23'd0, vq[i].exp_ctl, vq[i].exp_data});
        end
        vq.delete();
        dev_ctl  = 4'hF;
        dev_data = '0;
    endtask

    task automatic step16_check(input string name, input logic ec, input logic [7:0] ed);
        @(posedge clk);
        #1;
        check(name, {23'd0, out_ctl16, out_data16}, {23'd0, ec, ed});
    endtask

    initial begin
        int busy;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",   {23'd0, out_ctl, out_data},     {23'd0, 1'b1, 8'h00});
        check("rst_flags", {24'd0, ovf, err},              32'd0);
        check("rst_out16", {23'd0, out_ctl16, out_data16}, {23'd0, 1'b1, 8'h00});
        reset = 1'b1;

        // Four ports commit on the same edge; a second port-0 frame waits for port 3.
        add(4'hF, 32'h0404_0404, 1'b1, 8'h00);
        add(4'h0, 32'hD0C0_B0A0, 1'b1, 8'h00);
        add(4'h0, 32'hD1C1_B1A1, 1'b1, 8'h00);
        add(4'hF, 32'h0000_0004, 1'b1, 8'h04);
        add(4'hE, 32'h0000_00E0, 1'b0, 8'hA0);
        add(4'hE, 32'h0000_00E1, 1'b0, 8'hA1);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'hB0);
        add(4'hF, 32'h0, 1'b0, 8'hB1);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'hC0);
        add(4'hF, 32'h0, 1'b0, 8'hC1);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'hD0);
        add(4'hF, 32'h0, 1'b0, 8'hD1);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'hE0);
        add(4'hF, 32'h0, 1'b0, 8'hE1);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        run_vectors("rr4");
        check("rr4_flags", {24'd0, ovf, err}, 32'd0);

        // Write response on port 0: header appears after the edge following the commit.
        add(4'hF, 32'h0000_0004, 1'b1, 8'h00);
        add(4'hE, 32'h0000_0012, 1'b1, 8'h00);
        add(4'hE, 32'h0000_0040, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'h12);
        add(4'hF, 32'h0, 1'b0, 8'h40);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        run_vectors("wr_p0");

        // Read response on port 2: 8'h13 has Dlen code 2, so 2 + 4 = 6 body bytes.
        add(4'hF, 32'h0013_0000, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) add(4'hB, 32'(8'h21 + i) << 16, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h13);
        for (int i = 0; i < 6; i++) add(4'hF, 32'h0, 1'b0, 8'(8'h21 + i));
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        run_vectors("rd_p2");
        check("rd_p2_flags", {24'd0, ovf, err}, 32'd0);

        // Port 3: a read response truncated by a write-response header.
        add(4'hF, 32'h1300_0000, 1'b1, 8'h00);
        add(4'h7, 32'h0100_0000, 1'b1, 8'h00);
        add(4'h7, 32'h0200_0000, 1'b1, 8'h00);
        add(4'hF, 32'h0400_0000, 1'b1, 8'h00);
        add(4'h7, 32'hAA00_0000, 1'b1, 8'h00);
        add(4'h7, 32'hBB00_0000, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'hAA);
        add(4'hF, 32'h0, 1'b0, 8'hBB);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        run_vectors("abort_p3");
        check("abort_p3_err", {28'd0, err}, 32'h8);
        check("abort_p3_ovf", {28'd0, ovf}, 32'h0);

        // DEPTH=16: header 8'h23 needs 1 + 18 bytes, so the frame is dropped.
        dev_ctl16[1]  = 1'b1;
        dev_data16[1] = 8'h23;
        @(posedge clk);
        #1;
        check("ovf16_hdr", {28'd0, ovf16}, 32'h2);
        busy = 0;
        dev_ctl16[1] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            dev_data16[1] = 8'(i + 1);
            @(posedge clk);
            #1;
            if (out_ctl16 !== 1'b1 || out_data16 !== 8'h00) busy++;
        end
        dev_ctl16  = 4'hF;
        dev_data16 = '0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_ctl16 !== 1'b1 || out_data16 !== 8'h00) busy++;
        end
        check("ovf16_no_output", busy, 0);
        check("ovf16_err", {28'd0, err16}, 32'h0);
        dev_data16[1] = 8'h04;
        step16_check("wr16_hdr_in", 1'b1, 8'h00);
        dev_ctl16[1]  = 1'b0;
        dev_data16[1] = 8'h55;
        step16_check("wr16_b0_in", 1'b1, 8'h00);
        dev_data16[1] = 8'h66;
        step16_check("wr16_commit", 1'b1, 8'h00);
        dev_ctl16  = 4'hF;
        dev_data16 = '0;
        step16_check("wr16_hdr_out", 1'b1, 8'h04);
        step16_check("wr16_b0_out", 1'b0, 8'h55);
        step16_check("wr16_b1_out", 1'b0, 8'h66);
        step16_check("wr16_gap", 1'b1, 8'h00);
        check("ovf16_sticky", {28'd0, ovf16}, 32'h2);

        // Reset while a port-0 read response is being sent.
        add(4'hF, 32'h0000_0013, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) add(4'hE, 32'(8'h31 + i), 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h13);
        add(4'hF, 32'h0, 1'b0, 8'h31);
        run_vectors("rst_pre");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_out",   {23'd0, out_ctl, out_data}, {23'd0, 1'b1, 8'h00});
        check("rst_mid_flags", {24'd0, ovf, err},          32'd0);
        check("rst_mid_ovf16", {28'd0, ovf16},             32'd0);
        reset = 1'b1;
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0000_0004, 1'b1, 8'h00);
        add(4'hE, 32'h0000_0077, 1'b1, 8'h00);
        add(4'hE, 32'h0000_0088, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h04);
        add(4'hF, 32'h0, 1'b0, 8'h77);
        add(4'hF, 32'h0, 1'b0, 8'h88);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        add(4'hF, 32'h0, 1'b1, 8'h00);
        run_vectors("rst_post");
        check("rst_post_flags", {24'd0, ovf, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
